infifo_thread_scheduler: RTL and testbench

- Chooses which thread's input FIFO receives the next incoming packet.
- Drives thread_sel and the enable_cpu start pulse into the per-thread input-FIFO demux.
- Tracks per-thread occupancy. Grants round-robin among free threads and holds the selection for a whole packet, firstword through lastword.
- Gates the upstream packet source with in_rdy.

---
 rtl/infifo_thread_scheduler.sv | 137 +++++++++++++
 tb/tb_infifo_thread_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infifo_thread_scheduler.sv
// Input-FIFO thread scheduler: round-robin grant of free threads,
// per-packet select hold, start pulse and occupancy tracking.
module infifo_thread_scheduler #(
  parameter int NUM_THREADS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_wr,
  input  logic                   in_firstword,
  input  logic                   in_lastword,
  input  logic [NUM_THREADS-1:0] thread_done,
  output logic                   in_rdy,
  output logic [2:0]             thread_sel,
  output logic                   enable_cpu,
  output logic [NUM_THREADS-1:0] thread_busy,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RECEIVE,
    RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             sel_q, sel_d;
  logic [2:0]             last_q, last_d;
  logic                   rdy_q, rdy_d;
  logic                   en_q, en_d;
  logic [NUM_THREADS-1:0] busy_q, busy_d;
  logic [7:0]             err_q, err_d;

  logic                   found;
  logic [2:0]             pick;
  logic [3:0]             idx;
  logic                   err_inc;

  // Rotating search for the first free thread after the last grant
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      idx = {1'b0, last_q} + 4'd1 + 4'(k);
      if (idx >= 4'(NUM_THREADS)) idx = idx - 4'(NUM_THREADS);
      if (!found && !busy_q[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // Next-state, registered outputs, occupancy and error accounting
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rdy_d   = rdy_q;
    en_d    = 1'b0;
    err_inc = in_wr && !rdy_q;
    busy_d  = busy_q & ~thread_done;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        if (found) begin
          sel_d   = pick;
          rdy_d   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (in_wr) begin
          if (!in_firstword) begin
            err_inc = 1'b1;
          end else if (in_lastword) begin
            state_d = RELEASE;
            rdy_d   = 1'b0;
            en_d    = 1'b1;
          end else begin
            state_d = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        if (in_wr) begin
          if (in_lastword) begin
            state_d = RELEASE;
            rdy_d   = 1'b0;
            en_d    = 1'b1;
          end else if (in_firstword) begin
            err_inc = 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d        = IDLE;
        rdy_d          = 1'b0;
        last_d         = sel_q;
        busy_d[sel_q]  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b0;
      end
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      last_q  <= 3'(NUM_THREADS - 1);
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= '0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign in_rdy      = rdy_q;
  assign thread_sel  = sel_q;
  assign enable_cpu  = en_q;
  assign thread_busy = busy_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_infifo_thread_scheduler.sv
// Self-checking bench for infifo_thread_scheduler: vector table,
// directed corner sequences and a packet-level random reference model.
module tb_infifo_thread_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_wr, in_firstword, in_lastword;
  logic [7:0] thread_done;
  logic       in_rdy;
  logic [2:0] thread_sel;
  logic       enable_cpu;
  logic [7:0] thread_busy;
  logic [7:0] err_count;

  int ncmp = 0;
  int nbad = 0;

  infifo_thread_scheduler #(.NUM_THREADS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_wr        (in_wr),
    .in_firstword (in_firstword),
    .in_lastword  (in_lastword),
    .thread_done  (thread_done),
    .in_rdy       (in_rdy),
    .thread_sel   (thread_sel),
    .enable_cpu   (enable_cpu),
    .thread_busy  (thread_busy),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr, f, l;
    logic [7:0] done;
    logic       rdy;
    logic [2:0] sel;
    logic       en;
    logic [7:0] busy;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t v(logic wr, logic f, logic l, logic [7:0] d,
                             logic rdy, logic [2:0] sel, logic en,
                             logic [7:0] busy, logic [7:0] err);
    vec_t r;
    r.wr = wr; r.f = f; r.l = l; r.done = d;
    r.rdy = rdy; r.sel = sel; r.en = en; r.busy = busy; r.err = err;
    return r;
  endfunction

  function automatic int next_free(bit [7:0] b, int last);
    for (int i = 1; i <= 8; i++) begin
      int j;
      j = (last + i) % 8;
      if (!b[j]) return j;
    end
    return -1;
  endfunction

  function automatic int sat(int e);
    return (e < 255) ? e + 1 : 255;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drv(logic w, logic f, logic l, logic [7:0] d);
    in_wr        = w;
    in_firstword = f;
    in_lastword  = l;
    thread_done  = d;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_rdy(int bound);
    int n = 0;
    while (!in_rdy && n < bound) begin
      tick();
      n++;
    end
    chk("rdy_wait", int'(in_rdy), 1);
  endtask

  bit [7:0] mbusy;
  int       mlast;
  int       merr;

  initial begin
    tbl[0]  = v(0,0,0,8'h00, 1,0,0,8'h00,0);
    tbl[1]  = v(1,1,0,8'h00, 1,0,0,8'h00,0);
    tbl[2]  = v(1,0,0,8'h00, 1,0,0,8'h00,0);
    tbl[3]  = v(1,0,1,8'h00, 0,0,1,8'h00,0);
    tbl[4]  = v(0,0,0,8'h00, 0,0,0,8'h01,0);
    tbl[5]  = v(0,0,0,8'h00, 1,1,0,8'h01,0);
    tbl[6]  = v(1,1,0,8'h00, 1,1,0,8'h01,0);
    tbl[7]  = v(1,0,1,8'h00, 0,1,1,8'h01,0);
    tbl[8]  = v(0,0,0,8'h00, 0,1,0,8'h03,0);
    tbl[9]  = v(0,0,0,8'h00, 1,2,0,8'h03,0);
    tbl[10] = v(1,1,0,8'h00, 1,2,0,8'h03,0);
    tbl[11] = v(1,0,1,8'h00, 0,2,1,8'h03,0);
    tbl[12] = v(0,0,0,8'h00, 0,2,0,8'h07,0);
    tbl[13] = v(0,0,0,8'h00, 1,3,0,8'h07,0);
    tbl[14] = v(1,1,0,8'h00, 1,3,0,8'h07,0);
    tbl[15] = v(1,0,1,8'h00, 0,3,1,8'h07,0);
    tbl[16] = v(0,0,0,8'h00, 0,3,0,8'h0F,0);
    tbl[17] = v(0,0,0,8'h00, 1,4,0,8'h0F,0);
    tbl[18] = v(1,1,1,8'h00, 0,4,1,8'h0F,0);
    tbl[19] = v(0,0,0,8'h00, 0,4,0,8'h1F,0);
    tbl[20] = v(0,0,0,8'h00, 1,5,0,8'h1F,0);
    tbl[21] = v(1,0,0,8'h00, 1,5,0,8'h1F,1);
    tbl[22] = v(1,1,0,8'h00, 1,5,0,8'h1F,1);
    tbl[23] = v(1,1,0,8'h00, 1,5,0,8'h1F,2);
    tbl[24] = v(1,0,1,8'h00, 0,5,1,8'h1F,2);
    tbl[25] = v(1,0,0,8'h00, 0,5,0,8'h3F,3);
    tbl[26] = v(0,0,0,8'h00, 1,6,0,8'h3F,3);
    tbl[27] = v(1,1,1,8'h00, 0,6,1,8'h3F,3);
    tbl[28] = v(0,0,0,8'h41, 0,6,0,8'h7E,3);
    tbl[29] = v(0,0,0,8'h00, 1,7,0,8'h7E,3);
    tbl[30] = v(0,0,0,8'h08, 1,7,0,8'h76,3);
    tbl[31] = v(0,0,0,8'h80, 1,7,0,8'h76,3);

    // reset values
    do_reset();
    chk("rst_rdy",  int'(in_rdy), 0);
    chk("rst_sel",  int'(thread_sel), 0);
    chk("rst_en",   int'(enable_cpu), 0);
    chk("rst_busy", int'(thread_busy), 0);
    chk("rst_err",  int'(err_count), 0);

    // cycle-by-cycle vector table
    for (int i = 0; i < 32; i++) begin
      drv(tbl[i].wr, tbl[i].f, tbl[i].l, tbl[i].done);
      tick();
      chk($sformatf("tbl%0d_rdy", i),  int'(in_rdy),      int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_sel", i),  int'(thread_sel),  int'(tbl[i].sel));
      chk($sformatf("tbl%0d_en", i),   int'(enable_cpu),  int'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i), int'(thread_busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i),  int'(err_count),   int'(tbl[i].err));
    end
    drv(0, 0, 0, 0);

    // occupancy-limited grant and error saturation
    do_reset();
    tick();
    for (int i = 0; i < 8; i++) begin
      wait_rdy(6);
      chk("fill_sel", int'(thread_sel), i);
      drv(1, 1, 1, 0);
      tick();
      drv(0, 0, 0, 0);
      tick();
    end
    chk("fill_busy", int'(thread_busy), 8'hFF);
    repeat (5) tick();
    chk("full_rdy", int'(in_rdy), 0);
    drv(0, 0, 0, 8'h04);
    tick();
    drv(0, 0, 0, 0);
    chk("fb_busy", int'(thread_busy), 8'hFB);
    tick();
    chk("fb_rdy", int'(in_rdy), 1);
    chk("fb_sel", int'(thread_sel), 2);
    drv(1, 1, 0, 0);
    tick();
    drv(1, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0);
    chk("fb_en", int'(enable_cpu), 1);
    chk("fb_en_sel", int'(thread_sel), 2);
    tick();
    chk("ff_busy", int'(thread_busy), 8'hFF);
    chk("ff_en_off", int'(enable_cpu), 0);
    repeat (10) tick();
    chk("ff_rdy", int'(in_rdy), 0);
    chk("pre_sat_err", int'(err_count), 0);
    drv(1, 0, 0, 0);
    repeat (300) tick();
    drv(0, 0, 0, 0);
    chk("sat_err", int'(err_count), 255);
    drv(0, 0, 0, 8'h20);
    tick();
    drv(0, 0, 0, 0);
    chk("d5_busy", int'(thread_busy), 8'hDF);
    chk("d5_rdy0", int'(in_rdy), 0);
    tick();
    chk("d5_rdy", int'(in_rdy), 1);
    chk("d5_sel", int'(thread_sel), 5);

    // random packets against a packet-level model
    do_reset();
    mbusy = 8'h00;
    mlast = 7;
    merr  = 0;
    tick();
    for (int p = 0; p < 120; p++) begin
      int       exp_sel;
      int       len;
      int       j;
      logic [7:0] mask;
      bit       extra;
      wait_rdy(6);
      exp_sel = next_free(mbusy, mlast);
      chk("rnd_sel", int'(thread_sel), exp_sel);
      if ($urandom_range(3) == 0) begin
        drv(1, 0, 0, 0);
        tick();
        merr = sat(merr);
        drv(0, 0, 0, 0);
        chk("rnd_arm_rdy", int'(in_rdy), 1);
      end
      len = $urandom_range(4, 1);
      for (int w = 0; w < len; w++) begin
        bit fe;
        if (w > 0 && $urandom_range(2) == 0) begin
          drv(0, 0, 0, 0);
          tick();
        end
        fe = (w > 0) && (w < len - 1) && ($urandom_range(4) == 0);
        drv(1, (w == 0) || fe, w == len - 1, 0);
        if (fe) merr = sat(merr);
        tick();
        if (w < len - 1) chk("rnd_en_mid", int'(enable_cpu), 0);
      end
      chk("rnd_en", int'(enable_cpu), 1);
      chk("rnd_rel_sel", int'(thread_sel), exp_sel);
      mask  = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
      extra = ($urandom_range(3) == 0);
      drv(extra, 0, 0, mask);
      if (extra) merr = sat(merr);
      tick();
      drv(0, 0, 0, 0);
      mbusy = mbusy & ~mask;
      mbusy[exp_sel] = 1'b1;
      mlast = exp_sel;
      chk("rnd_busy", int'(thread_busy), int'(mbusy));
      chk("rnd_en_off", int'(enable_cpu), 0);
      if (mbusy == 8'hFF) begin
        repeat (3) tick();
        chk("rnd_full_rdy", int'(in_rdy), 0);
        j = $urandom_range(7);
        drv(0, 0, 0, 8'(1 << j));
        tick();
        drv(0, 0, 0, 0);
        mbusy[j] = 1'b0;
        chk("rnd_free_busy", int'(thread_busy), int'(mbusy));
      end
      chk("rnd_err", int'(err_count), merr);
    end

    // reset in the middle of a packet
    wait_rdy(6);
    drv(1, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_en",   int'(enable_cpu), 0);
    chk("mid_rst_busy", int'(thread_busy), 0);
    chk("mid_rst_rdy",  int'(in_rdy), 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_en2",  int'(enable_cpu), 0);
    chk("mid_rst_rdy2", int'(in_rdy), 1);
    chk("mid_rst_sel",  int'(thread_sel), 0);

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
